// File: rtl/id_decode_pkg.sv
// Shared constants for the RV32I decode stage: opcodes, ALU codes,
// control-bundle bit positions and immediate formats.
// Optional feature macro: DECODE_RV32M_EN (enables M-extension decode).
package id_decode_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CTRL_W  = 13;
  localparam int unsigned ALU_W   = 4;
  localparam int unsigned REG_W   = 5;

  // Major opcodes
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IARITH = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // R-type funct7 values
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // ALU operation codes
  localparam logic [ALU_W-1:0] ALU_AND  = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_OR   = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_ADD  = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_SLTU = 4'b0011;
  localparam logic [ALU_W-1:0] ALU_SUB  = 4'b0110;
  localparam logic [ALU_W-1:0] ALU_SLT  = 4'b0111;
  localparam logic [ALU_W-1:0] ALU_SRA  = 4'b1000;
  localparam logic [ALU_W-1:0] ALU_XOR  = 4'b1100;
  localparam logic [ALU_W-1:0] ALU_SLL  = 4'b1101;
  localparam logic [ALU_W-1:0] ALU_SRL  = 4'b1110;

  // Control bundle bit positions (MSB first)
  localparam int unsigned CTRL_ALU_SRC    = 12;
  localparam int unsigned CTRL_MEM_TO_REG = 11;
  localparam int unsigned CTRL_REG_WRITE  = 10;
  localparam int unsigned CTRL_MEM_READ   = 9;
  localparam int unsigned CTRL_MEM_WRITE  = 8;
  localparam int unsigned CTRL_LINK       = 7;
  localparam int unsigned CTRL_LUI        = 6;
  localparam int unsigned CTRL_AUIPC      = 5;
  localparam int unsigned CTRL_IS_BRANCH  = 4;
  localparam int unsigned CTRL_IS_JUMP    = 3;
  localparam int unsigned CTRL_JALR       = 2;
  localparam int unsigned CTRL_MULDIV     = 1;
  localparam int unsigned CTRL_ILLEGAL    = 0;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  // Register/immediate arithmetic op from funct3; alt is instr[30]
  function automatic logic [ALU_W-1:0] alu_from_funct3(input logic [2:0] funct3,
                                                        input logic       alt,
                                                        input logic       sub_ok);
    logic [ALU_W-1:0] code;
    case (funct3)
      3'b000:  code = (alt && sub_ok) ? ALU_SUB : ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = alt ? ALU_SRA : ALU_SRL;
      3'b110:  code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/id_decode_stage_if.sv
// IF/ID -> ID/EX handshake bundle of the decode stage.
// master: upstream/downstream environment; slave: the decode stage.
interface id_decode_stage_if #(
  parameter int unsigned XLEN = 32
);
  import id_decode_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [INSTR_W-1:0]   in_instr;
  logic [XLEN-1:0]      in_pc;
  logic                 flush;

  logic                 out_valid;
  logic                 out_ready;
  logic [CTRL_W-1:0]    out_ctrl;
  logic [ALU_W-1:0]     out_alu_cnt;
  logic [2:0]           out_funct3;
  logic [REG_W-1:0]     out_rs1;
  logic [REG_W-1:0]     out_rs2;
  logic [REG_W-1:0]     out_rd;
  logic [XLEN-1:0]      out_imm;
  logic [XLEN-1:0]      out_pc;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_ctrl, out_alu_cnt, out_funct3,
           out_rs1, out_rs2, out_rd, out_imm, out_pc
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_ctrl, out_alu_cnt, out_funct3,
           out_rs1, out_rs2, out_rd, out_imm, out_pc
  );

endinterface

// File: rtl/id_decode_comb.sv
// Combinational RV32I instruction decoder: control bundle, ALU code,
// register indices, sign-extended immediate and source-usage flags.
// Optional feature macro: DECODE_RV32M_EN.
module id_decode_comb
  import id_decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [INSTR_W-1:0] instr,
  output logic [CTRL_W-1:0]  ctrl,
  output logic [ALU_W-1:0]   alu_cnt,
  output logic [2:0]         funct3,
  output logic [REG_W-1:0]   rs1,
  output logic [REG_W-1:0]   rs2,
  output logic [REG_W-1:0]   rd,
  output logic [XLEN-1:0]    imm,
  output logic               uses_rs1,
  output logic               uses_rs2
);

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [31:0] imm32;
  imm_fmt_e    fmt;

  assign opcode = instr[6:0];
  assign funct7 = instr[31:25];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rd     = instr[11:7];

  // Main and ALU control decode by opcode/funct fields
  always_comb begin
    ctrl     = '0;
    alu_cnt  = ALU_ADD;
    fmt      = IMM_NONE;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OPC_R: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        if (funct7 == F7_BASE || funct7 == F7_ALT) begin
          ctrl[CTRL_MEM_TO_REG] = 1'b1;
          ctrl[CTRL_REG_WRITE]  = 1'b1;
          alu_cnt = alu_from_funct3(funct3, instr[30], 1'b1);
        end else if (funct7 == F7_MULDIV) begin
`ifdef DECODE_RV32M_EN
          ctrl[CTRL_MULDIV]     = 1'b1;
          ctrl[CTRL_REG_WRITE]  = 1'b1;
          ctrl[CTRL_MEM_TO_REG] = 1'b1;
`else
          ctrl[CTRL_ILLEGAL]    = 1'b1;
`endif
        end else begin
          ctrl[CTRL_ILLEGAL] = 1'b1;
        end
      end
      OPC_IARITH: begin
        uses_rs1 = 1'b1;
        fmt      = IMM_I;
        ctrl[CTRL_ALU_SRC]    = 1'b1;
        ctrl[CTRL_MEM_TO_REG] = 1'b1;
        ctrl[CTRL_REG_WRITE]  = 1'b1;
        alu_cnt = alu_from_funct3(funct3, instr[30], 1'b0);
      end
      OPC_LOAD: begin
        uses_rs1 = 1'b1;
        fmt      = IMM_I;
        ctrl[CTRL_ALU_SRC]   = 1'b1;
        ctrl[CTRL_REG_WRITE] = 1'b1;
        ctrl[CTRL_MEM_READ]  = 1'b1;
      end
      OPC_STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        fmt      = IMM_S;
        ctrl[CTRL_ALU_SRC]   = 1'b1;
        ctrl[CTRL_MEM_WRITE] = 1'b1;
      end
      OPC_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        fmt      = IMM_B;
        case (funct3)
          3'b000, 3'b001: begin
            ctrl[CTRL_IS_BRANCH] = 1'b1;
            alu_cnt = ALU_SUB;
          end
          3'b100, 3'b101: begin
            ctrl[CTRL_IS_BRANCH] = 1'b1;
            alu_cnt = ALU_SLT;
          end
          3'b110, 3'b111: begin
            ctrl[CTRL_IS_BRANCH] = 1'b1;
            alu_cnt = ALU_SLTU;
          end
          default: ctrl[CTRL_ILLEGAL] = 1'b1;
        endcase
      end
      OPC_JAL: begin
        fmt = IMM_J;
        ctrl[CTRL_LINK]      = 1'b1;
        ctrl[CTRL_IS_JUMP]   = 1'b1;
        ctrl[CTRL_REG_WRITE] = 1'b1;
      end
      OPC_JALR: begin
        uses_rs1 = 1'b1;
        fmt      = IMM_I;
        ctrl[CTRL_LINK]      = 1'b1;
        ctrl[CTRL_IS_JUMP]   = 1'b1;
        ctrl[CTRL_JALR]      = 1'b1;
        ctrl[CTRL_REG_WRITE] = 1'b1;
        ctrl[CTRL_ALU_SRC]   = 1'b1;
      end
      OPC_LUI: begin
        fmt = IMM_U;
        ctrl[CTRL_LUI]       = 1'b1;
        ctrl[CTRL_REG_WRITE] = 1'b1;
        ctrl[CTRL_ALU_SRC]   = 1'b1;
      end
      OPC_AUIPC: begin
        fmt = IMM_U;
        ctrl[CTRL_AUIPC]     = 1'b1;
        ctrl[CTRL_REG_WRITE] = 1'b1;
        ctrl[CTRL_ALU_SRC]   = 1'b1;
      end
      default: ctrl[CTRL_ILLEGAL] = 1'b1;
    endcase
  end

  // Immediate assembly per format, sign-extended from bit 31
  always_comb begin
    imm32 = 32'h0;
    case (fmt)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'h000};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = 32'h0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/id_decode_stage.sv
// Registered RV32I decode stage: ID/EX bundle register behind a
// valid/ready handshake, load-use bubble insertion, flush and a
// saturating stall counter.
// Optional feature macro: DECODE_RV32M_EN (handled in id_decode_comb).
module id_decode_stage
  import id_decode_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned HAZ_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  id_decode_stage_if.slave     bus,
  output logic [HAZ_CNT_W-1:0] haz_cnt
);

  logic [CTRL_W-1:0]    dec_ctrl;
  logic [ALU_W-1:0]     dec_alu_cnt;
  logic [2:0]           dec_funct3;
  logic [REG_W-1:0]     dec_rs1;
  logic [REG_W-1:0]     dec_rs2;
  logic [REG_W-1:0]     dec_rd;
  logic [XLEN-1:0]      dec_imm;
  logic                 dec_uses_rs1;
  logic                 dec_uses_rs2;

  logic                 out_valid_q;
  logic [CTRL_W-1:0]    ctrl_q;
  logic [ALU_W-1:0]     alu_cnt_q;
  logic [2:0]           funct3_q;
  logic [REG_W-1:0]     rs1_q;
  logic [REG_W-1:0]     rs2_q;
  logic [REG_W-1:0]     rd_q;
  logic [XLEN-1:0]      imm_q;
  logic [XLEN-1:0]      pc_q;
  logic [HAZ_CNT_W-1:0] haz_cnt_q;

  logic                 hazard_c;
  logic                 fire_in_c;
  logic                 fire_out_c;

  id_decode_comb #(
    .XLEN (XLEN)
  ) u_decode (
    .instr    (bus.in_instr),
    .ctrl     (dec_ctrl),
    .alu_cnt  (dec_alu_cnt),
    .funct3   (dec_funct3),
    .rs1      (dec_rs1),
    .rs2      (dec_rs2),
    .rd       (dec_rd),
    .imm      (dec_imm),
    .uses_rs1 (dec_uses_rs1),
    .uses_rs2 (dec_uses_rs2)
  );

  // Load in ID/EX whose destination feeds the incoming instruction
  assign hazard_c = out_valid_q && ctrl_q[CTRL_MEM_READ] && (rd_q != '0) &&
                    ((dec_uses_rs1 && (dec_rs1 == rd_q)) ||
                     (dec_uses_rs2 && (dec_rs2 == rd_q)));

  assign bus.in_ready = !bus.flush && !hazard_c && (!out_valid_q || bus.out_ready);
  assign fire_in_c    = bus.in_valid && bus.in_ready;
  assign fire_out_c   = out_valid_q && bus.out_ready;

  // ID/EX register update: flush > bubble > load > drain > hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      alu_cnt_q   <= '0;
      funct3_q    <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      haz_cnt_q   <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (hazard_c && bus.out_ready) begin
      out_valid_q <= 1'b0;
      if (haz_cnt_q != '1) begin
        haz_cnt_q <= haz_cnt_q + HAZ_CNT_W'(1);
      end
    end else if (fire_in_c) begin
      out_valid_q <= 1'b1;
      ctrl_q      <= dec_ctrl;
      alu_cnt_q   <= dec_alu_cnt;
      funct3_q    <= dec_funct3;
      rs1_q       <= dec_rs1;
      rs2_q       <= dec_rs2;
      rd_q        <= dec_rd;
      imm_q       <= dec_imm;
      pc_q        <= bus.in_pc;
    end else if (fire_out_c) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_ctrl    = ctrl_q;
  assign bus.out_alu_cnt = alu_cnt_q;
  assign bus.out_funct3  = funct3_q;
  assign bus.out_rs1     = rs1_q;
  assign bus.out_rs2     = rs2_q;
  assign bus.out_rd      = rd_q;
  assign bus.out_imm     = imm_q;
  assign bus.out_pc      = pc_q;
  assign haz_cnt         = haz_cnt_q;

endmodule

// File: tb/tb_id_decode_stage.sv
// Self-checking bench for id_decode_stage: directed steps followed by
// randomized traffic, compared against a behavioural model.
// Honours DECODE_RV32M_EN when computing expectations.
module tb_id_decode_stage;

  localparam int unsigned XLEN = 32;

`ifdef DECODE_RV32M_EN
  localparam bit RV32M = 1'b1;
`else
  localparam bit RV32M = 1'b0;
`endif

  // Control bundle bit positions, MSB to LSB
  localparam int B_ALU_SRC  = 12;
  localparam int B_REG_WR   = 10;
  localparam int B_BRANCH   = 4;
  localparam int B_MULDIV   = 1;
  localparam int B_ILLEGAL  = 0;
  localparam int B_MEM_READ = 9;

  typedef struct packed {
    logic [12:0] ctrl;
    logic [3:0]  alu;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        u1;
    logic        u2;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] haz_cnt;

  id_decode_stage_if #(.XLEN(XLEN)) bus ();

  id_decode_stage #(
    .XLEN      (XLEN),
    .HAZ_CNT_W (16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .haz_cnt (haz_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;

  logic        m_valid;
  exp_t        m_b;
  logic [31:0] m_pc;
  logic [15:0] m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference decode straight from the opcode tables
  function automatic exp_t ref_decode(input logic [31:0] ins);
    exp_t       e;
    logic [6:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    logic       a_src, m2r, rw, mr, mw, lnk, lu, aui, br, jp, jr, md, ill;
    logic [3:0] alu;
    int         imm;
    logic [3:0] alu_of_f3 [8];
    alu_of_f3 = '{4'b0010, 4'b1101, 4'b0111, 4'b0011, 4'b1100, 4'b1110, 4'b0001, 4'b0000};
    op = ins[6:0];
    f7 = ins[31:25];
    f3 = ins[14:12];
    {a_src, m2r, rw, mr, mw, lnk, lu, aui, br, jp, jr, md, ill} = 13'h0;
    alu = 4'b0010;
    imm = 0;
    e = '0;
    case (op)
      7'b0110011: begin
        e.u1 = 1'b1; e.u2 = 1'b1;
        if (f7 == 7'h00 || f7 == 7'h20) begin
          m2r = 1'b1; rw = 1'b1;
          alu = alu_of_f3[f3];
          if (f7 == 7'h20 && f3 == 3'd0) alu = 4'b0110;
          if (f7 == 7'h20 && f3 == 3'd5) alu = 4'b1000;
        end else if (f7 == 7'h01 && RV32M) begin
          md = 1'b1; rw = 1'b1; m2r = 1'b1;
        end else begin
          ill = 1'b1;
        end
      end
      7'b0010011: begin
        e.u1 = 1'b1;
        a_src = 1'b1; m2r = 1'b1; rw = 1'b1;
        alu = alu_of_f3[f3];
        if (f3 == 3'd5 && ins[30]) alu = 4'b1000;
        imm = $signed(ins[31:20]);
      end
      7'b0000011: begin
        e.u1 = 1'b1;
        a_src = 1'b1; rw = 1'b1; mr = 1'b1;
        imm = $signed(ins[31:20]);
      end
      7'b0100011: begin
        e.u1 = 1'b1; e.u2 = 1'b1;
        a_src = 1'b1; mw = 1'b1;
        imm = $signed({ins[31:25], ins[11:7]});
      end
      7'b1100011: begin
        e.u1 = 1'b1; e.u2 = 1'b1;
        imm = $signed({ins[31], ins[7], ins[30:25], ins[11:8]}) * 2;
        if (f3 == 3'd2 || f3 == 3'd3) ill = 1'b1;
        else begin
          br = 1'b1;
          alu = (f3 < 3'd4) ? 4'b0110 : (f3 < 3'd6) ? 4'b0111 : 4'b0011;
        end
      end
      7'b1101111: begin
        lnk = 1'b1; jp = 1'b1; rw = 1'b1;
        imm = $signed({ins[31], ins[19:12], ins[20], ins[30:21]}) * 2;
      end
      7'b1100111: begin
        e.u1 = 1'b1;
        lnk = 1'b1; jp = 1'b1; jr = 1'b1; rw = 1'b1; a_src = 1'b1;
        imm = $signed(ins[31:20]);
      end
      7'b0110111: begin
        lu = 1'b1; rw = 1'b1; a_src = 1'b1;
        imm = $signed({ins[31:12], 12'h000});
      end
      7'b0010111: begin
        aui = 1'b1; rw = 1'b1; a_src = 1'b1;
        imm = $signed({ins[31:12], 12'h000});
      end
      default: ill = 1'b1;
    endcase
    e.ctrl = {a_src, m2r, rw, mr, mw, lnk, lu, aui, br, jp, jr, md, ill};
    e.alu  = alu;
    e.f3   = f3;
    e.rs1  = ins[19:15];
    e.rs2  = ins[24:20];
    e.rd   = ins[11:7];
    e.imm  = 32'(imm);
    return e;
  endfunction

  function automatic logic model_hazard();
    exp_t d;
    d = ref_decode(bus.in_instr);
    return m_valid && m_b.ctrl[B_MEM_READ] && (m_b.rd != 5'd0) &&
           ((d.u1 && d.rs1 == m_b.rd) || (d.u2 && d.rs2 == m_b.rd));
  endfunction

  function automatic logic model_ready();
    return !bus.flush && !model_hazard() && (!m_valid || bus.out_ready);
  endfunction

  task automatic check_outputs();
    chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
    chk("in_ready", 64'(bus.in_ready), 64'(model_ready()));
    chk("haz_cnt", 64'(haz_cnt), 64'(m_cnt));
    if (m_valid) begin
      chk("ctrl", 64'(bus.out_ctrl), 64'(m_b.ctrl));
      chk("alu_cnt", 64'(bus.out_alu_cnt), 64'(m_b.alu));
      chk("funct3", 64'(bus.out_funct3), 64'(m_b.f3));
      chk("rs1", 64'(bus.out_rs1), 64'(m_b.rs1));
      chk("rs2", 64'(bus.out_rs2), 64'(m_b.rs2));
      chk("rd", 64'(bus.out_rd), 64'(m_b.rd));
      chk("imm", 64'(bus.out_imm), 64'(m_b.imm));
      chk("pc", 64'(bus.out_pc), 64'(m_pc));
    end
  endtask

  task automatic model_step();
    logic haz;
    logic rdy;
    haz = model_hazard();
    rdy = model_ready();
    if (bus.flush) begin
      m_valid = 1'b0;
    end else if (haz && bus.out_ready) begin
      m_valid = 1'b0;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else if (bus.in_valid && rdy) begin
      m_valid = 1'b1;
      m_b     = ref_decode(bus.in_instr);
      m_pc    = bus.in_pc;
    end else if (m_valid && bus.out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  // Check at the falling edge, advance the model, return just after the rising edge
  task automatic tick();
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    bus.in_valid = v;
    bus.in_instr = ins;
    bus.in_pc    = pc;
  endtask

  function automatic logic [31:0] gen_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] r;
    int          k;
    rd  = 5'($urandom_range(0, 3));
    rs1 = 5'($urandom_range(0, 3));
    rs2 = 5'($urandom_range(0, 3));
    f3  = 3'($urandom);
    r   = $urandom;
    k   = $urandom_range(0, 11);
    case ($urandom_range(0, 3))
      0:       f7 = 7'h00;
      1:       f7 = 7'h20;
      2:       f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    case (k)
      0, 1:    return {f7, rs2, rs1, f3, rd, 7'b0110011};
      2:       return {r[11:0], rs1, f3, rd, 7'b0010011};
      3, 4:    return {r[11:0], rs1, 3'b010, rd, 7'b0000011};
      5:       return {r[6:0], rs2, rs1, 3'b010, r[11:7], 7'b0100011};
      6:       return {r[6:0], rs2, rs1, f3, r[11:7], 7'b1100011};
      7:       return {r[19:0], rd, 7'b1101111};
      8:       return {r[11:0], rs1, 3'b000, rd, 7'b1100111};
      9:       return {r[19:0], rd, 7'b0110111};
      10:      return {r[19:0], rd, 7'b0010111};
      default: return r;
    endcase
  endfunction

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_LW   = 32'hFFC0A283;
  localparam logic [31:0] I_ADD2 = 32'h00228333;
  localparam logic [31:0] I_BEQ  = 32'hFE208CE3;
  localparam logic [31:0] I_ADDI = 32'h00500393;
  localparam logic [31:0] I_XOR  = 32'h0020C433;
  localparam logic [31:0] I_BAD  = 32'h0000007F;
  localparam logic [31:0] I_MUL  = 32'h02208033;

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = 32'h0;
    bus.in_pc     = 32'h0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    m_valid       = 1'b0;
    m_b           = '0;
    m_pc          = 32'h0;
    m_cnt         = 16'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst.haz_cnt", 64'(haz_cnt), 64'd0);
    chk("rst.ctrl", 64'(bus.out_ctrl), 64'd0);
    chk("rst.imm", 64'(bus.out_imm), 64'd0);
    chk("rst.rd", 64'(bus.out_rd), 64'd0);
    rst_n = 1'b1;

    // add x3,x1,x2
    bus.out_ready = 1'b1;
    drive(1'b1, I_ADD, 32'h100);
    tick();
    chk("add.valid", 64'(bus.out_valid), 64'd1);
    chk("add.alu", 64'(bus.out_alu_cnt), 64'h2);
    chk("add.reg_write", 64'(bus.out_ctrl[B_REG_WR]), 64'd1);
    chk("add.rd", 64'(bus.out_rd), 64'd3);
    chk("add.imm", 64'(bus.out_imm), 64'd0);

    // Load-use: lw x5 then add using x5
    drive(1'b1, I_LW, 32'h104);
    tick();
    chk("lw.imm", 64'(bus.out_imm), 64'hFFFFFFFC);
    drive(1'b1, I_ADD2, 32'h108);
    #1;
    chk("lu.in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    chk("lu.bubble", 64'(bus.out_valid), 64'd0);
    chk("lu.haz_cnt", 64'(haz_cnt), 64'd1);
    tick();
    chk("lu.issue", 64'(bus.out_valid), 64'd1);
    chk("lu.rd", 64'(bus.out_rd), 64'd6);

    // beq x1,x2,-8
    drive(1'b1, I_BEQ, 32'h10C);
    tick();
    chk("beq.branch", 64'(bus.out_ctrl[B_BRANCH]), 64'd1);
    chk("beq.alu", 64'(bus.out_alu_cnt), 64'h6);
    chk("beq.imm", 64'(bus.out_imm), 64'hFFFFFFF8);
    chk("beq.reg_write", 64'(bus.out_ctrl[B_REG_WR]), 64'd0);

    // Backpressure hold, then flush
    drive(1'b1, I_ADDI, 32'h110);
    tick();
    bus.out_ready = 1'b0;
    drive(1'b1, I_XOR, 32'h114);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold.valid", 64'(bus.out_valid), 64'd1);
      chk("hold.rd", 64'(bus.out_rd), 64'd7);
      chk("hold.imm", 64'(bus.out_imm), 64'd5);
      chk("hold.in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.flush = 1'b1;
    tick();
    chk("flush.valid", 64'(bus.out_valid), 64'd0);
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("flush.dropped", 64'(bus.out_valid), 64'd0);

    // Illegal opcode and mul
    drive(1'b1, I_BAD, 32'h200);
    tick();
    chk("bad.ctrl", 64'(bus.out_ctrl), 64'h1);
    chk("bad.alu", 64'(bus.out_alu_cnt), 64'h2);
    drive(1'b1, I_MUL, 32'h204);
    tick();
    chk("mul.illegal", 64'(bus.out_ctrl[B_ILLEGAL]), RV32M ? 64'd0 : 64'd1);
    chk("mul.muldiv", 64'(bus.out_ctrl[B_MULDIV]), RV32M ? 64'd1 : 64'd0);
    chk("mul.alu_src", 64'(bus.out_ctrl[B_ALU_SRC]), 64'd0);
    drive(1'b0, 32'h0, 32'h0);
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_instr  = gen_instr();
      bus.in_pc     = $urandom & 32'hFFFF_FFFC;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 15) == 0);
      tick();
    end

    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_decode_stage.md
Name: id_decode_stage

Overview:
- Registered RV32I decode stage that replaces the purely combinational main/ALU control pair.
- Decodes one instruction per cycle into a full control bundle: main control, 4-bit ALU control code and sign-extended immediate.
- Holds the bundle in an ID/EX output register behind a valid/ready handshake.
- Detects load-use hazards and inserts a bubble; honours pipeline flush; counts stall cycles.

Parameters:
- XLEN, 32, datapath width for pc and imm; legal values 32 or 64; decode is always RV32I, imm is sign-extended to XLEN.
- HAZ_CNT_W, 16, width of the saturating load-use stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  IF/ID holds a valid instruction.
- in_ready  out  1  stage accepts in_instr/in_pc this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  pc of in_instr.
- flush  in  1  kill the held bundle and the incoming instruction (taken branch/jump resolved in EX).
- out_valid  out  1  the bundle is valid.
- out_ready  in  1  EX consumes the bundle.
- out_ctrl  out  13  {alu_src, mem_to_reg, reg_write, mem_read, mem_write, link, lui, auipc, is_branch, is_jump, jalr, muldiv, illegal}, in that order MSB to LSB.
- out_alu_cnt  out  4  ALU operation code.
- out_funct3  out  3  funct3, passed through.
- out_rs1, out_rs2, out_rd  out  5 each  register indices.
- out_imm  out  XLEN  sign-extended immediate.
- out_pc  out  XLEN  pc.
- haz_cnt  out  HAZ_CNT_W  number of load-use bubble cycles, saturating.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, every bundle field=0, haz_cnt=0. in_ready is combinational and therefore 0 while a flush or hazard is active.
- Definitions:
  - fire_in = in_valid & in_ready.
  - fire_out = out_valid & out_ready.
  - Latency: 1 cycle from fire_in to out_valid.
- Hazard condition: out_valid & mem_read & (out_rd!=0) & ((uses_rs1 & rs1==out_rd) | (uses_rs2 & rs2==out_rd)).
  - uses_rs1: R, I-arith, load, store, branch, jalr.
  - uses_rs2: R, store, branch.
- in_ready = ~flush & ~hazard & (~out_valid | out_ready).
- Register update priority, highest first:
  - flush: out_valid<=0. The incoming instruction is dropped.
  - hazard & out_ready: out_valid<=0 (one bubble). haz_cnt increments, saturating at all-ones.
  - fire_in: load the new bundle, out_valid<=1.
  - fire_out without fire_in: out_valid<=0.
  - Otherwise: hold; the bundle stays stable while out_valid & ~out_ready.
- Opcode decode (alu_src, mem_to_reg, reg_write, mem_read, mem_write, link, jump):
  - 0110011 R: 0,1,1,0,0,0,0.
  - 0010011 I-arith: 1,1,1,0,0,0,0.
  - 0000011 load: 1,0,1,1,0,0,0.
  - 0100011 store: 1,0,0,0,1,0,0.
  - 1100011 branch: alu_src=0, reg_write=0, is_branch=1.
  - 1101111 jal: link=1, is_jump=1, reg_write=1.
  - 1100111 jalr: link=1, is_jump=1, jalr=1, reg_write=1, alu_src=1.
  - 0110111 lui: lui=1, reg_write=1, alu_src=1.
  - 0010111 auipc: auipc=1, reg_write=1, alu_src=1.
  - Any other opcode: illegal=1, all other controls 0, alu_cnt=0010. No X or Z values are ever driven.
- ALU codes: ADD 0010, SUB 0110, SLT 0111, SLTU 0011, AND 0000, OR 0001, XOR 1100, SLL 1101, SRL 1110, SRA 1000.
  - Load, store, jal, jalr, lui and auipc use ADD.
  - Branch: BEQ/BNE use SUB; BLT/BGE use SLT; BLTU/BGEU use SLTU.
  - R-type and I-arith decode by funct3.
  - funct7 bit 5 selects SUB (R-type only) and SRA/SRAI.
  - R-type funct7 not in {0000000, 0100000}: illegal=1.
  - Branch funct3 010 or 011: illegal=1.
- Immediate formats:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - All sign-extended from bit 31 to XLEN. imm=0 for R-type.
- Flush and hazard in the same cycle: flush wins; haz_cnt is not incremented.

Optional Feature:
- Macro DECODE_RV32M_EN.
- Defined: opcode 0110011 with funct7=0000001 decodes as muldiv=1, reg_write=1, mem_to_reg=1, alu_cnt=0010; the operation is carried on out_funct3.
- Undefined: the same encoding yields illegal=1, and muldiv is tied to 0.

Decomposition:
- Package id_decode_pkg holds:
  - opcode localparams;
  - ALU code localparams;
  - ctrl bit-index constants;
  - the immediate-format enum (I/S/B/U/J/NONE).
- One combinational sub-module, id_decode_comb: instr in, bundle fields out. The stage wraps it with the hazard, handshake and register logic.

Test Plan:
- Reset then `add x3,x1,x2` (0x002081B3) with in_valid, out_ready=1 → next cycle: out_valid=1, alu_cnt=0010, reg_write=1, rd=3, imm=0.
- `lw x5,-4(x1)` (0xFFC0A283) followed by `add x6,x5,x2` → one bubble (out_valid=0 for 1 cycle), in_ready=0 that cycle, haz_cnt=1, then the add issues.
- `beq x1,x2,-8` (0xFE208CE3) → is_branch=1, alu_cnt=0110, imm=0xFFFFFFF8, reg_write=0.
- Hold out_ready=0 for 3 cycles with in_valid=1 → bundle stable, in_ready=0; flush asserted → out_valid=0 next cycle, incoming instruction dropped.
- Opcode 0x0000007F, then `mul` (0x02208033) with and without DECODE_RV32M_EN → illegal=1 for both when the macro is undefined; muldiv=1, illegal=0 for mul when defined.
